updown_sweep_ctrl: RTL and testbench

- Controller that sequences a synchronous W-bit up/down counter between programmable bounds `lo` and `hi`.
- Supports three sweep modes: wrap, bounce (ping-pong) and one-shot.
- Counts completed sweeps against a programmable target, and supports pause and abort.
- Sits between a host/config interface and the counter datapath. It replaces free-running up/down control with bounded, scheduled sweeps.

---
 rtl/sweep_pkg.sv | 20 ++
 rtl/updown_cnt.sv | 36 +++
 rtl/updown_sweep_ctrl.sv | 170 +++++++++++++++++
 tb/tb_updown_sweep_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// Shared types and constants for the bounded up/down sweep controller.
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [1:0] MODE_WRAP    = 2'd0;
  localparam logic [1:0] MODE_BOUNCE  = 2'd1;
  localparam logic [1:0] MODE_ONESHOT = 2'd2;

  // Reserved encoding 3 behaves as one-shot.
  function automatic logic is_oneshot(input logic [1:0] mode);
    return (mode != MODE_WRAP) && (mode != MODE_BOUNCE);
  endfunction

endpackage

// File: rtl/updown_cnt.sv
// W-bit synchronous up/down counter with parallel load; load wins over enable.
module updown_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (en) begin
      q_d = up ? W'(q_q + W'(1)) : W'(q_q - W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Sequences an up/down counter through bounded wrap, bounce or one-shot sweeps,
// counting completed sweeps against a latched target.
module updown_sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int unsigned W  = 4,
  parameter int unsigned SW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          pause,
  input  logic [1:0]    mode,
  input  logic [W-1:0]  lo,
  input  logic [W-1:0]  hi,
  input  logic [SW-1:0] sweeps,
  output logic [W-1:0]  q,
  output logic          up,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [SW-1:0] sweep_cnt
);

  state_e        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [SW-1:0] tgt_q, tgt_d;
  logic [SW-1:0] sweep_cnt_q, sweep_cnt_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [SW-1:0] sweep_nxt_c;
  logic          tgt_hit_c;
  logic          cnt_load_c;
  logic          cnt_en_c;
  logic          cnt_up_c;
  logic [W-1:0]  cnt_d_c;
  logic [W-1:0]  cnt_q_c;

  updown_cnt #(
    .W(W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (cnt_en_c),
    .up   (cnt_up_c),
    .load (cnt_load_c),
    .d    (cnt_d_c),
    .q    (cnt_q_c)
  );

  // Completed-sweep count saturates so an unbounded run never wraps to zero.
  assign sweep_nxt_c = (sweep_cnt_q == '1) ? sweep_cnt_q : SW'(sweep_cnt_q + SW'(1));
  assign tgt_hit_c   = (tgt_q != '0) && (sweep_nxt_c == tgt_q);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    tgt_d       = tgt_q;
    sweep_cnt_d = sweep_cnt_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    cnt_load_c  = 1'b0;
    cnt_en_c    = 1'b0;
    cnt_up_c    = 1'b0;
    cnt_d_c     = cnt_q_c;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          mode_d = mode;
          lo_d   = lo;
          hi_d   = hi;
          tgt_d  = sweeps;
          if (lo >= hi) begin
            err_d = 1'b1;
          end else begin
            cnt_load_c  = 1'b1;
            cnt_d_c     = lo;
            sweep_cnt_d = '0;
            state_d     = UP;
          end
        end
      end

      UP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!pause) begin
          if (cnt_q_c != hi_q) begin
            cnt_en_c = 1'b1;
            cnt_up_c = 1'b1;
          end else begin
            sweep_cnt_d = sweep_nxt_c;
            if (tgt_hit_c || is_oneshot(mode_q)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else if (mode_q == MODE_WRAP) begin
              cnt_load_c = 1'b1;
              cnt_d_c    = lo_q;
            end else begin
              cnt_load_c = 1'b1;
              cnt_d_c    = W'(hi_q - W'(1));
              state_d    = DOWN;
            end
          end
        end
      end

      DOWN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!pause) begin
          if (cnt_q_c != lo_q) begin
            cnt_en_c = 1'b1;
          end else begin
            sweep_cnt_d = sweep_nxt_c;
            if (tgt_hit_c) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              cnt_load_c = 1'b1;
              cnt_d_c    = W'(lo_q + W'(1));
              state_d    = UP;
            end
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      tgt_q       <= '0;
      sweep_cnt_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      tgt_q       <= tgt_d;
      sweep_cnt_q <= sweep_cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign q         = cnt_q_c;
  assign up        = (state_q == UP);
  assign busy      = (state_q == UP) || (state_q == DOWN);
  assign done      = done_q;
  assign err       = err_q;
  assign sweep_cnt = sweep_cnt_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a direction/position model.
module tb_updown_sweep_ctrl;

  localparam int W  = 4;
  localparam int SW = 8;
  localparam int CNT_MAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst, start, abort, pause;
  logic [1:0]    mode;
  logic [W-1:0]  lo, hi, q;
  logic [SW-1:0] sweeps, sweep_cnt;
  logic          up, busy, done, err;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model: a run is a position moving in direction +1/-1 between latched bounds.
  bit m_run, m_fin, m_done, m_err;
  int m_q, m_cnt, m_dir;
  int m_mode, m_lo, m_hi, m_tgt;

  updown_sweep_ctrl #(.W(W), .SW(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pause(pause),
    .mode(mode), .lo(lo), .hi(hi), .sweeps(sweeps),
    .q(q), .up(up), .busy(busy), .done(done), .err(err), .sweep_cnt(sweep_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int bound;
    if (rst) begin
      m_run = 0; m_fin = 0; m_done = 0; m_err = 0;
      m_q = 0; m_cnt = 0; m_dir = 1;
    end else begin
      m_done = 0;
      m_err  = 0;
      if (m_fin) begin
        m_fin = 0;
      end else if (!m_run) begin
        if (start && !abort) begin
          m_mode = int'(mode); m_lo = int'(lo); m_hi = int'(hi); m_tgt = int'(sweeps);
          if (m_lo >= m_hi) begin
            m_err = 1;
          end else begin
            m_q = m_lo; m_cnt = 0; m_run = 1; m_dir = 1;
          end
        end
      end else if (abort) begin
        m_run = 0;
      end else if (!pause) begin
        bound = (m_dir > 0) ? m_hi : m_lo;
        if (m_q != bound) begin
          m_q += m_dir;
        end else begin
          if (m_cnt < CNT_MAX) m_cnt++;
          if ((m_tgt != 0 && m_cnt == m_tgt) || m_mode >= 2) begin
            m_run = 0; m_fin = 1; m_done = 1;
          end else if (m_mode == 0) begin
            m_q = m_lo;
          end else begin
            m_dir = -m_dir;
            m_q += m_dir;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model.q", int'(q), m_q);
      chk("model.up", int'(up), int'(m_run && m_dir > 0));
      chk("model.busy", int'(busy), int'(m_run));
      chk("model.done", int'(done), int'(m_done));
      chk("model.err", int'(err), int'(m_err));
      chk("model.sweep_cnt", int'(sweep_cnt), m_cnt);
      chk("err_done_excl", int'(err && done), 0);
    end
  end

  // Called just after a negedge; returns at the negedge where q=lo is visible.
  task automatic start_run(input int m, input int l, input int h, input int s);
    mode = 2'(m); lo = W'(l); hi = W'(h); sweeps = SW'(s);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int exp_wrap[8]   = '{2, 3, 4, 5, 2, 3, 4, 5};
    int exp_bq[10]    = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3};
    int exp_bu[10]    = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1};
    int lo_r;
    rst = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
    mode = '0; lo = '0; hi = '0; sweeps = '0;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.q", int'(q), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.sweep_cnt", int'(sweep_cnt), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle.q", int'(q), 0);
    chk("idle.busy", int'(busy), 0);

    start_run(0, 2, 5, 2);
    for (int i = 0; i < 8; i++) begin
      chk("wrap.q", int'(q), exp_wrap[i]);
      @(negedge clk);
    end
    chk("wrap.done", int'(done), 1);
    chk("wrap.q_end", int'(q), 5);
    chk("wrap.sweep_cnt", int'(sweep_cnt), 2);
    @(negedge clk);
    chk("wrap.done_off", int'(done), 0);
    chk("wrap.idle", int'(busy), 0);

    start_run(1, 0, 3, 3);
    for (int i = 0; i < 10; i++) begin
      chk("bounce.q", int'(q), exp_bq[i]);
      chk("bounce.up", int'(up), exp_bu[i]);
      @(negedge clk);
    end
    chk("bounce.done", int'(done), 1);
    chk("bounce.sweep_cnt", int'(sweep_cnt), 3);
    chk("bounce.q_end", int'(q), 3);
    @(negedge clk);

    start_run(2, 0, 15, 0);
    for (int i = 0; i < 16; i++) begin
      chk("oneshot.q", int'(q), i);
      chk("oneshot.busy", int'(busy), 1);
      @(negedge clk);
    end
    chk("oneshot.done", int'(done), 1);
    chk("oneshot.sweep_cnt", int'(sweep_cnt), 1);
    chk("oneshot.q_end", int'(q), 15);
    @(negedge clk);
    chk("oneshot.done_off", int'(done), 0);

    start_run(0, 7, 7, 1);
    chk("inv_eq.err", int'(err), 1);
    chk("inv_eq.busy", int'(busy), 0);
    chk("inv_eq.q", int'(q), 15);
    @(negedge clk);
    chk("inv_eq.err_off", int'(err), 0);
    start_run(1, 9, 3, 1);
    chk("inv_gt.err", int'(err), 1);
    chk("inv_gt.q", int'(q), 15);
    @(negedge clk);

    start_run(0, 0, 9, 0);
    repeat (4) @(negedge clk);
    chk("pause.q_before", int'(q), 4);
    pause = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("pause.q_hold", int'(q), 4);
      chk("pause.busy", int'(busy), 1);
    end
    pause = 1'b0;
    @(negedge clk);
    chk("pause.resume", int'(q), 5);
    repeat (2) @(negedge clk);
    chk("abort.q_before", int'(q), 7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort.busy", int'(busy), 0);
    chk("abort.q", int'(q), 7);
    chk("abort.done", int'(done), 0);
    chk("abort.sweep_cnt", int'(sweep_cnt), 0);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort.busy", int'(busy), 0);
    chk("start_abort.err", int'(err), 0);
    chk("start_abort.q", int'(q), 7);

    start_run(0, 0, 1, 0);
    repeat (520) @(negedge clk);
    chk("sat.sweep_cnt", int'(sweep_cnt), CNT_MAX);
    chk("sat.busy", int'(busy), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 39) == 0);
      pause = ($urandom_range(0, 5) == 0);
      rst   = ($urandom_range(0, 499) == 0);
      mode  = 2'($urandom_range(0, 3));
      sweeps = SW'($urandom_range(0, 4));
      if ($urandom_range(0, 4) == 0) begin
        lo = W'($urandom_range(0, 15));
        hi = W'($urandom_range(0, 15));
      end else begin
        lo_r = int'($urandom_range(0, 14));
        lo = W'(lo_r);
        hi = W'($urandom_range(lo_r + 1, 15));
      end
      @(negedge clk);
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0; pause = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
